// File: rtl/matvec_core_if.sv
// Sink (weights/vector) and source (results) valid/ready streams of matvec_core.
// master = feeder/writeback side, slave = the core.
interface matvec_core_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 18
);
  logic                  snk_vld;
  logic                  snk_rdy;
  logic [DATA_WIDTH-1:0] snk_data;
  logic                  src_vld;
  logic                  src_rdy;
  logic [ACC_WIDTH-1:0]  src_data;
  logic                  src_last;

  modport master (
    output snk_vld, snk_data, src_rdy,
    input  snk_rdy, src_vld, src_data, src_last
  );

  modport slave (
    input  snk_vld, snk_data, src_rdy,
    output snk_rdy, src_vld, src_data, src_last
  );
endinterface

// File: rtl/matvec_core.sv
// Signed matrix-vector multiply engine y = W*x, one MAC per cycle, optional resident W.
// Optional feature: define MATVEC_RELU_EN to clamp negative results to zero.
module matvec_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4,
  parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + $clog2(DIM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keep_w_i,
  output logic            busy_o,
  matvec_core_if.slave    bus
);
  localparam int unsigned NW = DIM*DIM;
  localparam int unsigned IW = $clog2(NW);
  localparam int unsigned CW = $clog2(DIM);
  localparam int unsigned PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {S_LOAD_W, S_LOAD_V, S_COMPUTE, S_DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [IW-1:0]                ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]                row_q, row_d, col_q, col_d, k_q, k_d, k_nxt;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum, y_val;
  logic                         src_vld_q, src_vld_d, src_last_q, src_last_d;
  logic                         busy_q, busy_d;
  logic [ACC_WIDTH-1:0]         src_data_q, src_data_d;
  logic                         snk_rdy_c, snk_hs, w_we, x_we, y_we;
  logic [IW-1:0]                w_idx;
  logic signed [PW-1:0]         prod;

  logic signed [DATA_WIDTH-1:0] w_q [NW];
  logic signed [DATA_WIDTH-1:0] x_q [DIM];
  logic signed [ACC_WIDTH-1:0]  y_q [DIM];

  // Ready is a pure state decode, forced low while reset is held
  assign snk_rdy_c    = !rst && (state_q == S_LOAD_W || state_q == S_LOAD_V);
  assign snk_hs       = bus.snk_vld && snk_rdy_c;
  assign bus.snk_rdy  = snk_rdy_c;
  assign bus.src_vld  = src_vld_q;
  assign bus.src_data = src_data_q;
  assign bus.src_last = src_last_q;
  assign busy_o       = busy_q;

  assign w_idx   = IW'(row_q) * IW'(DIM) + IW'(col_q);
  assign prod    = PW'(w_q[w_idx]) * PW'(x_q[col_q]);
  assign acc_sum = ACC_WIDTH'(prod) + ((col_q == '0) ? ACC_WIDTH'(0) : acc_q);
  assign k_nxt   = k_q + CW'(1);

`ifdef MATVEC_RELU_EN
  assign y_val = acc_sum[ACC_WIDTH-1] ? '0 : acc_sum;
`else
  assign y_val = acc_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD_W;
      ld_cnt_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      src_vld_q  <= 1'b0;
      src_data_q <= '0;
      src_last_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      src_vld_q  <= src_vld_d;
      src_data_q <= src_data_d;
      src_last_q <= src_last_d;
      busy_q     <= busy_d;
    end
  end

  // Weight, vector and result storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NW); i++)  w_q[i] <= '0;
      for (int i = 0; i < int'(DIM); i++) x_q[i] <= '0;
      for (int i = 0; i < int'(DIM); i++) y_q[i] <= '0;
    end else begin
      if (w_we) w_q[ld_cnt_q] <= $signed(bus.snk_data);
      if (x_we) x_q[ld_cnt_q[CW-1:0]] <= $signed(bus.snk_data);
      if (y_we) y_q[row_q] <= y_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    acc_d      = acc_q;
    src_vld_d  = src_vld_q;
    src_data_d = src_data_q;
    src_last_d = src_last_q;
    busy_d     = busy_q;
    w_we       = 1'b0;
    x_we       = 1'b0;
    y_we       = 1'b0;

    unique case (state_q)
      S_LOAD_W: begin
        if (snk_hs) begin
          w_we = 1'b1;
          if (ld_cnt_q == IW'(NW-1)) begin
            ld_cnt_d = '0;
            state_d  = S_LOAD_V;
          end else begin
            ld_cnt_d = ld_cnt_q + IW'(1);
          end
        end
      end
      S_LOAD_V: begin
        if (snk_hs) begin
          x_we = 1'b1;
          if (ld_cnt_q == IW'(DIM-1)) begin
            ld_cnt_d = '0;
            row_d    = '0;
            col_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_COMPUTE;
          end else begin
            ld_cnt_d = ld_cnt_q + IW'(1);
          end
        end
      end
      S_COMPUTE: begin
        acc_d = acc_sum;
        if (col_q == CW'(DIM-1)) begin
          y_we  = 1'b1;
          col_d = '0;
          if (row_q == CW'(DIM-1)) begin
            // y[0] was committed DIM-1 rows ago, so it can be presented now
            row_d      = '0;
            k_d        = '0;
            src_vld_d  = 1'b1;
            src_data_d = y_q[0];
            src_last_d = 1'b0;
            state_d    = S_DRAIN;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.src_rdy) begin
          if (k_q == CW'(DIM-1)) begin
            k_d        = '0;
            src_vld_d  = 1'b0;
            src_data_d = '0;
            src_last_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = keep_w_i ? S_LOAD_V : S_LOAD_W;
          end else begin
            k_d        = k_nxt;
            src_data_d = y_q[k_nxt];
            src_last_d = (k_nxt == CW'(DIM-1));
          end
        end
      end
      default: state_d = S_LOAD_W;
    endcase
  end
endmodule
